set_bit_scanner: RTL and testbench
==================================

// Module: set_bit_scanner
// PURPOSE
//  Expands a word back into its set bits: accepts a width-bit vector and emits the
//  index of each set bit, one per beat, over a valid/ready stream. The counterpart of
//  OR reduction, which condenses many bits into one. Used for sticky-bit, exception
//  and request lists, where each asserted bit must be serviced individually.
// PARAMETERS
//  width  8                  vector width, >= 1
//  idxw   $clog2(width)>1?:1 index width (localparam; 1 when width == 1)
// PORTS
//  clk_i        in   1      clock, rising edge
//  rst_ni       in   1      reset, asynchronous, active-low
//  A_valid_i    in   1      input vector valid
//  A_ready_o    out  1      input vector accepted when A_valid_i & A_ready_o
//  A_i          in   width  vector to scan
//  Idx_valid_o  out  1      output beat valid
//  Idx_ready_i  in   1      output beat consumed when Idx_valid_o & Idx_ready_i
//  Idx_o        out  idxw   index of the current set bit
//  Last_o       out  1      final beat for the current vector
//  Empty_o      out  1      accepted vector was all-zero (only beat, Idx_o = 0)
// BEHAVIOUR
//  - One clock, one reset: asynchronous, active-low.
//  - Reset values: A_ready_o = 1, Idx_valid_o = 0, Idx_o = 0, Last_o = 0, Empty_o = 0.
//    State = IDLE; mask register = 0.
//  - FSM IDLE:
//    - A_ready_o = 1, Idx_valid_o = 0.
//    - On accept, mask <= A_i; next state EMIT.
//  - FSM EMIT:
//    - A_ready_o = 0, Idx_valid_o = 1.
//    - Idx_o = position of the lowest set bit of mask.
//    - Last_o = 1 when mask has exactly one bit set, or when mask == 0.
//    - Empty_o = 1 when mask == 0 (detected via OR reduction of mask).
//  - On output handshake in EMIT:
//    - Clear bit Idx_o in mask.
//    - If Last_o, go to IDLE; else stay in EMIT.
//  - Latency: first beat valid 1 cycle after accept. Then 1 beat/cycle with
//    Idx_ready_i held high.
//  - Throughput: n set bits take n EMIT cycles (1 for all-zero) plus 1 IDLE cycle.
//    A_ready_o is never high in the same cycle as a Last handshake.
//  - Stall: while Idx_valid_o & !Idx_ready_i, Idx_o, Last_o and Empty_o stay stable.
//  - Input rules:
//    - A_i is sampled only on accept; later changes to A_i are ignored.
//    - A_valid_i may drop without acceptance; no state change.
//  - Full vector (all ones): exactly width beats, indices ascending, Last_o on the final one.
//  - width == 1:
//    - A = 1 gives one beat: Idx_o = 0, Last_o = 1, Empty_o = 0.
//    - A = 0 gives one beat: Empty_o = 1.
//  - Reset asserted mid-scan: immediate return to reset values. Remaining bits are
//    discarded and no further beats are emitted.
//  - All outputs are registered or decoded from registered state only; there is no
//    combinational path from inputs to outputs.
// CONFIGURATION
//  SET_BIT_SCANNER_MSB_FIRST_EN:
//  - Defined: scan from the highest set bit downward. Idx_o = highest set bit of mask.
//  - Undefined (default): scan from the lowest set bit upward.
//  - All other behaviour, including Last_o, Empty_o, timing and reset, is identical.
// TESTING
//  1. width = 8; accept A = 8'b1010_0100; Idx_ready_i = 1.
//     -> beats 2, 5, 7 on consecutive cycles; Last_o only with 7; A_ready_o high the next cycle.
//  2. Accept A = 8'h00.
//     -> single beat: Idx_o = 0, Empty_o = 1, Last_o = 1. Then IDLE.
//  3. Accept A = 8'hFF; Idx_ready_i toggles 1,0,1,0.
//     -> indices 0..7 in order, each held stable across its stall cycle, 8 handshakes total.
//  4. Accept A = 8'h81; drive rst_ni low after the first beat (idx 0).
//     -> Idx_valid_o = 0 and A_ready_o = 1 immediately; no beat 7 after reset release.
//  5. With SET_BIT_SCANNER_MSB_FIRST_EN defined, accept A = 8'b0001_0011.
//     -> beats 4, 1, 0; Last_o with 0.
//  6. width = 1: accept A = 1 then A = 0.
//     -> beat {Idx_o 0, Last_o 1, Empty_o 0}, then beat {Empty_o 1, Last_o 1}.

Source files
------------

// File: rtl/set_bit_scanner.sv
`default_nettype none
// ============================================================================
// Module      : set_bit_scanner
// Description : Expands a vector into the indices of its set bits, one index
//               per beat, over a valid/ready stream. An all-zero vector
//               produces a single beat flagged Empty (index 0). Each accepted
//               vector ends with a beat flagged Last.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   1      clock, rising edge
//   rst_ni       in   1      reset, asynchronous, active-low
//   A_valid_i    in   1      input vector valid
//   A_ready_o    out  1      input vector accepted when A_valid_i & A_ready_o
//   A_i          in   width  vector to scan
//   Idx_valid_o  out  1      output beat valid
//   Idx_ready_i  in   1      output beat consumed when Idx_valid_o & Idx_ready_i
//   Idx_o        out  idxw   index of the current set bit
//   Last_o       out  1      final beat for the current vector
//   Empty_o      out  1      accepted vector was all-zero
// Configuration
//   SET_BIT_SCANNER_MSB_FIRST_EN : when defined, indices are emitted from the
//   highest set bit downward; otherwise from the lowest set bit upward.
// ============================================================================
module set_bit_scanner #(
  parameter  int width = 8,
  localparam int idxw  = (width > 1) ? $clog2(width) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             A_valid_i,
  output logic             A_ready_o,
  input  logic [width-1:0] A_i,
  output logic             Idx_valid_o,
  input  logic             Idx_ready_i,
  output logic [idxw-1:0]  Idx_o,
  output logic             Last_o,
  output logic             Empty_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [width-1:0] mask;
  logic [width-1:0] mask_next;
  logic [idxw-1:0]  sel_idx;
  logic             mask_zero;
  logic             mask_single;
  logic             emitting;

  // Priority encoder over the remaining bits. The loop direction makes the
  // last matching iteration win, which selects the lowest (or highest) bit.
  always_comb begin
    sel_idx = '0;
`ifdef SET_BIT_SCANNER_MSB_FIRST_EN
    for (int i = 0; i < width; i++) begin
      if (mask[i]) sel_idx = i[idxw-1:0];
    end
`else
    for (int i = width - 1; i >= 0; i--) begin
      if (mask[i]) sel_idx = i[idxw-1:0];
    end
`endif
  end

  assign mask_zero   = ~|mask;
  // x & (x-1) clears the lowest set bit; zero result means at most one bit.
  assign mask_single = !mask_zero && ((mask & (mask - width'(1))) == '0);
  assign emitting    = (state == EMIT);

  // Outputs are decoded from registered state only; gating with EMIT keeps
  // them at their reset values while idle even though mask is zero there.
  assign A_ready_o   = (state == IDLE);
  assign Idx_valid_o = emitting;
  assign Idx_o       = emitting ? sel_idx : '0;
  assign Last_o      = emitting && (mask_single || mask_zero);
  assign Empty_o     = emitting && mask_zero;

  always_comb begin
    state_next = state;
    mask_next  = mask;
    case (state)
      IDLE: begin
        if (A_valid_i) begin
          mask_next  = A_i;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (Idx_ready_i) begin
          mask_next = mask & ~(width'(1) << sel_idx);
          if (mask_single || mask_zero) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        mask_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      mask  <= '0;
    end else begin
      state <= state_next;
      mask  <= mask_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_set_bit_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_bit_scanner
// Description : Self-checking bench for set_bit_scanner (width 8 and width 1).
//               Expected index sequences come from a queue-based model built
//               directly from the bits of each vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_bit_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a;
  logic       idx_valid;
  logic       idx_ready;
  logic [2:0] idx;
  logic       last;
  logic       empty;

  logic       u_a_valid;
  logic       u_a_ready;
  logic [0:0] u_a;
  logic       u_valid;
  logic       u_ready;
  logic [0:0] u_idx;
  logic       u_last;
  logic       u_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  set_bit_scanner #(.width(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .A_valid_i  (a_valid),
    .A_ready_o  (a_ready),
    .A_i        (a),
    .Idx_valid_o(idx_valid),
    .Idx_ready_i(idx_ready),
    .Idx_o      (idx),
    .Last_o     (last),
    .Empty_o    (empty)
  );

  set_bit_scanner #(.width(1)) dut_w1 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .A_valid_i  (u_a_valid),
    .A_ready_o  (u_a_ready),
    .A_i        (u_a),
    .Idx_valid_o(u_valid),
    .Idx_ready_i(u_ready),
    .Idx_o      (u_idx),
    .Last_o     (u_last),
    .Empty_o    (u_empty)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the list of set-bit positions in scan order; [0] when empty.
  task automatic build_model(input logic [7:0] v);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
`ifdef SET_BIT_SCANNER_MSB_FIRST_EN
        exp_q.push_front(i);
`else
        exp_q.push_back(i);
`endif
      end
    end
    if (exp_q.size() == 0) exp_q.push_back(0);
  endtask

  // mode 0: ready always high, 1: ready toggles 1,0,1,0..., 2: random ready
  // plus random A_valid/A traffic during the scan (must be ignored).
  task automatic run_vector(input logic [7:0] v, input int mode,
                            output int nb, output int f_idx, output int l_idx);
    int k, cyc, n;
    bit stalled, tog, rdy;
    int h_idx, h_last, h_empty;
    build_model(v);
    n = exp_q.size();
    k = 0; cyc = 0; stalled = 0; tog = 1;
    f_idx = -1; l_idx = -1;
    h_idx = 0; h_last = 0; h_empty = 0;
    @(negedge clk);
    check("idle_a_ready", int'(a_ready), 1);
    check("idle_idx_valid", int'(idx_valid), 0);
    a_valid = 1'b1;
    a = v;
    @(negedge clk);
    a_valid = 1'b0;
    a = 8'($urandom);
    while (k < n && cyc < 64) begin
      check("emit_idx_valid", int'(idx_valid), 1);
      check("emit_a_ready_low", int'(a_ready), 0);
      if (stalled) begin
        check("stall_idx", int'(idx), h_idx);
        check("stall_last", int'(last), h_last);
        check("stall_empty", int'(empty), h_empty);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = !tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      idx_ready = rdy;
      if (mode == 2) begin
        a_valid = 1'($urandom_range(0, 1));
        a = 8'($urandom);
      end
      if (rdy) begin
        check("beat_idx", int'(idx), exp_q[k]);
        check("beat_last", int'(last), (k == n - 1) ? 1 : 0);
        check("beat_empty", int'(empty), (v == 8'h00) ? 1 : 0);
        if (k == 0) f_idx = int'(idx);
        l_idx = int'(idx);
        k++;
        stalled = 0;
        if (k == n) a_valid = 1'b0;
      end else begin
        stalled = 1;
        h_idx = int'(idx);
        h_last = int'(last);
        h_empty = int'(empty);
      end
      @(negedge clk);
      cyc++;
    end
    idx_ready = 1'b0;
    a_valid = 1'b0;
    if (k < n) check("scan_timeout_beats", k, n);
    nb = k;
    check("post_a_ready", int'(a_ready), 1);
    check("post_idx_valid", int'(idx_valid), 0);
    if (mode == 0) check("beats_per_cycle", cyc, n);
  endtask

  typedef struct {
    logic [7:0] v;
    int         nb;
    int         first_i;
    int         final_i;
    int         mode;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int nb, fi, li;
    logic [7:0] v;
    int r;

    // Positions listed for LSB-first order; swapped below for MSB-first.
    tbl[0] = '{8'b1010_0100, 3, 2, 7, 0};
    tbl[1] = '{8'h00,        1, 0, 0, 0};
    tbl[2] = '{8'hFF,        8, 0, 7, 1};
    tbl[3] = '{8'h81,        2, 0, 7, 0};
    tbl[4] = '{8'h10,        1, 4, 4, 1};
    tbl[5] = '{8'b0001_0011, 3, 0, 4, 0};

    rst_n = 1'b0;
    a_valid = 1'b0; a = 8'h00; idx_ready = 1'b0;
    u_a_valid = 1'b0; u_a = 1'b0; u_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_ready", int'(a_ready), 1);
    check("rst_idx_valid", int'(idx_valid), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_last", int'(last), 0);
    check("rst_empty", int'(empty), 0);
    rst_n = 1'b1;

    // Table-driven directed vectors
    for (int t = 0; t < 6; t++) begin
      run_vector(tbl[t].v, tbl[t].mode, nb, fi, li);
      check("tbl_beats", nb, tbl[t].nb);
`ifdef SET_BIT_SCANNER_MSB_FIRST_EN
      check("tbl_first", fi, tbl[t].final_i);
      check("tbl_final", li, tbl[t].first_i);
`else
      check("tbl_first", fi, tbl[t].first_i);
      check("tbl_final", li, tbl[t].final_i);
`endif
    end

    // Reset asserted mid-scan
    build_model(8'h81);
    @(negedge clk);
    a_valid = 1'b1; a = 8'h81;
    @(negedge clk);
    a_valid = 1'b0;
    idx_ready = 1'b1;
    check("rstmid_first_idx", int'(idx), exp_q[0]);
    @(negedge clk);
    check("rstmid_second_valid", int'(idx_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_idx_valid", int'(idx_valid), 0);
    check("rstmid_a_ready", int'(a_ready), 1);
    check("rstmid_idx", int'(idx), 0);
    check("rstmid_last", int'(last), 0);
    check("rstmid_empty", int'(empty), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rstmid_no_beat", int'(idx_valid), 0);
    end
    idx_ready = 1'b0;

    // width == 1 instance: A = 1 then A = 0
    @(negedge clk);
    u_a_valid = 1'b1; u_a = 1'b1;
    @(negedge clk);
    u_a_valid = 1'b0; u_a = 1'b0;
    check("w1_one_valid", int'(u_valid), 1);
    check("w1_one_idx", int'(u_idx), 0);
    check("w1_one_last", int'(u_last), 1);
    check("w1_one_empty", int'(u_empty), 0);
    u_ready = 1'b1;
    @(negedge clk);
    u_ready = 1'b0;
    check("w1_one_done", int'(u_valid), 0);
    check("w1_ready", int'(u_a_ready), 1);
    u_a_valid = 1'b1; u_a = 1'b0;
    @(negedge clk);
    u_a_valid = 1'b0;
    check("w1_zero_valid", int'(u_valid), 1);
    check("w1_zero_idx", int'(u_idx), 0);
    check("w1_zero_last", int'(u_last), 1);
    check("w1_zero_empty", int'(u_empty), 1);
    u_ready = 1'b1;
    @(negedge clk);
    u_ready = 1'b0;
    check("w1_zero_done", int'(u_valid), 0);

    // Randomized vectors with random backpressure and input noise
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 7);
      v = 8'($urandom);
      if (r == 0) v = 8'h00;
      if (r == 1) v = 8'hFF;
      run_vector(v, 2, nb, fi, li);
      check("rand_beats", nb, (v == 8'h00) ? 1 : $countones(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
